serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 161 ++++++++++++++++
 tb/tb_serial_adder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: sum = a + b + cin (mod 2^WIDTH), one bit per clock, LSB first.
// Latency: out_valid rises WIDTH+1 edges after the accepting edge (accept + WIDTH RUN edges).
// Backpressure: result held in DONE until out_ready; in_ready low from accept until back in IDLE.
//
// Ports:
//   clk, rst             sole clock; asynchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, cin sampled only while IDLE)
//   a, b, cin            operands and carry-in for bit 0
//   out_valid/out_ready  result handshake; sum, cout (and ovf) held while out_valid
//   sum, cout            registered result and carry out of bit WIDTH-1
//   ovf                  two's-complement overflow, present only with SERIAL_ADDER_OVF_EN defined
//
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds the ovf output and its register).

// One-bit full-adder cell used for every bit position of the serial sum.
module fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    // Counter must be able to hold WIDTH itself so the final increment never wraps.
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               last_bit;
    logic               fa_s;
    logic               fa_co;
    logic [WIDTH-1:0]   sum_shift;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    fa u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at sum[0].
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_shift = fa_s;
        end else begin : g_wn
            assign sum_shift = {fa_s, sum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are flops loaded from the next state, so they track the
    // state register exactly without any combinational path from the inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + CNT_W'(1);
                    sum   <= sum_shift;
                    if (last_bit) begin
                        cout <= fa_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the MSB cycle the carry flop holds the carry into the MSB; overflow is
    // that carry disagreeing with the carry out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == RUN && last_bit) begin
            ovf <= carry ^ fa_co;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int N_RND = 500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- directed DUT, WIDTH=8 ----------------
    logic       d_rst;
    logic       d_in_valid;
    logic       d_in_ready;
    logic [7:0] d_a;
    logic [7:0] d_b;
    logic       d_cin;
    logic       d_out_valid;
    logic       d_out_ready;
    logic [7:0] d_sum;
    logic       d_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic       d_ovf;
`endif

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (d_rst),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .a         (d_a),
        .b         (d_b),
        .cin       (d_cin),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .sum       (d_sum),
        .cout      (d_cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (d_ovf)
`endif
    );

    // Caller is at a negedge with the DUT idle. Drives one operation, pokes junk
    // operands with in_valid high during RUN, holds out_ready low for 'hold' cycles.
    task automatic op8(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                       input logic xc, input int hold,
                       input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        int bad;
        logic [7:0] s0;
        logic c0;
        d_in_valid  = 1'b1;
        d_a         = xa;
        d_b         = xb;
        d_cin       = xc;
        d_out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        check_val({tag, "_busy"}, 64'(d_in_ready), 64'd0);
        while (!d_out_valid && lat < 40) begin
            d_in_valid = 1'b1;
            d_a        = 8'hAA;
            d_b        = 8'($urandom);
            d_cin      = 1'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        d_in_valid = 1'b0;
        check_val({tag, "_lat"}, 64'(lat), 64'd9);
        check_val({tag, "_sum"}, 64'(d_sum), 64'(es));
        check_val({tag, "_cout"}, 64'(d_cout), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check_val({tag, "_ovf"}, 64'(d_ovf), 64'(eo));
`endif
        s0  = d_sum;
        c0  = d_cout;
        bad = 0;
        repeat (hold) begin
            d_in_valid = 1'b1;
            d_a        = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (!d_out_valid || d_in_ready || d_sum !== s0 || d_cout !== c0) bad++;
        end
        check_val({tag, "_hold"}, 64'(bad), 64'd0);
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_out_ready = 1'b0;
        check_val({tag, "_ovld_clr"}, 64'(d_out_valid), 64'd0);
        check_val({tag, "_rdy_back"}, 64'(d_in_ready), 64'd1);
    endtask

    // ---------------- random DUTs at WIDTH 1, 8, 33 ----------------
    logic r_rst;

    for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
        localparam int W = (gi == 0) ? 1 : ((gi == 1) ? 8 : 33);
        logic         iv;
        logic         ir;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         ci;
        logic         ov;
        logic         orr;
        logic [W-1:0] rs;
        logic         co;
`ifdef SERIAL_ADDER_OVF_EN
        logic         ovf_r;
`endif

        serial_adder #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst       (r_rst),
            .in_valid  (iv),
            .in_ready  (ir),
            .a         (ra),
            .b         (rb),
            .cin       (ci),
            .out_valid (ov),
            .out_ready (orr),
            .sum       (rs),
            .cout      (co)
`ifdef SERIAL_ADDER_OVF_EN
            ,
            .ovf       (ovf_r)
`endif
        );

        initial begin
            logic [W-1:0] xa;
            logic [W-1:0] xb;
            logic         xc;
            logic [63:0]  r64;
            logic [63:0]  mask;
            logic [64:0]  full;
            logic [64:0]  low;
            logic [W-1:0] s0;
            int lat;
            int hold;
            int bad;
            iv  = 1'b0;
            ra  = '0;
            rb  = '0;
            ci  = 1'b0;
            orr = 1'b0;
            @(negedge clk);
            while (r_rst) @(negedge clk);
            for (int n = 0; n < N_RND; n++) begin
                r64 = {$urandom(), $urandom()};
                xa  = r64[W-1:0];
                r64 = {$urandom(), $urandom()};
                xb  = r64[W-1:0];
                xc  = 1'($urandom);
                // Reference: plain arithmetic on the operand values.
                full = 65'(xa) + 65'(xb) + 65'(xc);
                mask = (64'd1 << (W - 1)) - 64'd1;
                low  = 65'(64'(xa) & mask) + 65'(64'(xb) & mask) + 65'(xc);
                iv = 1'b1;
                ra = xa;
                rb = xb;
                ci = xc;
                @(posedge clk);
                lat = 1;
                @(negedge clk);
                while (!ov && lat < W + 10) begin
                    r64 = {$urandom(), $urandom()};
                    iv  = 1'($urandom);
                    ra  = r64[W-1:0];
                    rb  = r64[63:64-W];
                    ci  = 1'($urandom);
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                end
                iv = 1'b0;
                check_val($sformatf("w%0d_lat", W), 64'(lat), 64'(W + 1));
                check_val($sformatf("w%0d_sum", W), 64'(rs), 64'(full[W-1:0]));
                check_val($sformatf("w%0d_cout", W), 64'(co), 64'(full[W]));
`ifdef SERIAL_ADDER_OVF_EN
                check_val($sformatf("w%0d_ovf", W), 64'(ovf_r), 64'(low[W-1] ^ full[W]));
`endif
                s0   = rs;
                bad  = 0;
                hold = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
                repeat (hold) begin
                    iv = 1'($urandom);
                    @(posedge clk);
                    @(negedge clk);
                    if (!ov || ir || rs !== s0) bad++;
                end
                check_val($sformatf("w%0d_hold", W), 64'(bad), 64'd0);
                iv  = 1'b0;
                orr = 1'b1;
                @(posedge clk);
                @(negedge clk);
                orr = 1'b0;
                check_val($sformatf("w%0d_idle", W), {63'd0, ir & ~ov}, 64'd1);
            end
            done_cnt++;
        end
    end

    // ---------------- main directed sequence ----------------
    initial begin
        int seen;
        d_rst       = 1'b1;
        r_rst       = 1'b1;
        d_in_valid  = 1'b0;
        d_a         = '0;
        d_b         = '0;
        d_cin       = 1'b0;
        d_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", 64'(d_in_ready), 64'd1);
        check_val("rst_out_valid", 64'(d_out_valid), 64'd0);
        check_val("rst_sum", 64'(d_sum), 64'd0);
        check_val("rst_cout", 64'(d_cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check_val("rst_ovf", 64'(d_ovf), 64'd0);
`endif
        // Release and offer the first operation on the same negedge: the first
        // rising edge with rst low must accept it (checked via latency).
        d_rst = 1'b0;
        r_rst = 1'b0;
        op8("ff_01", 8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0);
        op8("7f_01", 8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1);
        op8("80_80", 8'h80, 8'h80, 1'b0, 2, 8'h00, 1'b1, 1'b1);
        op8("35_4a_hold", 8'h35, 8'h4A, 1'b1, 20, 8'h80, 1'b0, 1'b1);
        op8("12_34_poke", 8'h12, 8'h34, 1'b0, 1, 8'h46, 1'b0, 1'b0);

        // Abort: reset during RUN cycle 4 must discard the operation.
        d_in_valid = 1'b1;
        d_a        = 8'h55;
        d_b        = 8'h22;
        d_cin      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        d_rst = 1'b1;
        #1;
        check_val("abort_sum_now", 64'(d_sum), 64'd0);
        check_val("abort_ovld_now", 64'(d_out_valid), 64'd0);
        @(negedge clk);
        d_rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (d_out_valid) seen++;
        end
        check_val("abort_no_result", 64'(seen), 64'd0);
        check_val("abort_sum", 64'(d_sum), 64'd0);
        check_val("abort_cout", 64'(d_cout), 64'd0);
        check_val("abort_rdy", 64'(d_in_ready), 64'd1);
        op8("01_02", 8'h01, 8'h02, 1'b0, 0, 8'h03, 1'b0, 1'b0);

        for (int t = 0; t < 60000 && done_cnt < 3; t++) @(posedge clk);
        check_val("rnd_done", 64'(done_cnt), 64'd3);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
